fetch_queue: RTL and testbench

N-wide instruction fetch unit between the instruction ROM and DECODE, generalising the fixed dual-instruction fetch.
- Owns the PC and issues FETCH_WIDTH-aligned block requests to a synchronous ROM with 1-cycle read latency.
- Buffers returned instructions with their PCs in a circular queue.
- Presents up to FETCH_WIDTH in-order instructions per cycle to decode; decode consumes a variable count.
- Supports redirect (branch/jump) with flush and squash of the in-flight request.

---
 rtl/fetch_queue.sv | 192 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: N-wide instruction fetch unit. Owns the fetch PC, issues
// block-aligned reads to a 1-cycle-latency ROM and buffers the returned
// instructions with their PCs in a circular queue for decode.
// Optional build macro FETCH_QUEUE_PERF_EN adds saturating perf counters.

module fetch_queue_chk #(
  parameter int unsigned CW          = 4,
  parameter int unsigned QUEUE_DEPTH = 8
) (
  input logic          i_clk,
  input logic          i_rst_n,
  input logic          i_redirect_valid,
  input logic [CW-1:0] i_count,
  input logic [CW-1:0] i_enq_n,
  input logic [CW-1:0] i_deq_n
);
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !i_redirect_valid |-> ((int'(i_count) + int'(i_enq_n) - int'(i_deq_n)) <= int'(QUEUE_DEPTH)));
endmodule

module fetch_queue #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     FETCH_WIDTH = 2,
  parameter int unsigned     QUEUE_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_redirect_valid,
  input  logic [XLEN-1:0]                      i_redirect_pc,
  output logic                                 o_rom_en,
  output logic [XLEN-1:0]                      o_rom_addr,
  input  logic [FETCH_WIDTH*XLEN-1:0]          i_rom_inst,
  output logic [FETCH_WIDTH*XLEN-1:0]          o_inst,
  output logic [FETCH_WIDTH*XLEN-1:0]          o_pc,
  output logic [FETCH_WIDTH-1:0]               o_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]     i_deq_count,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]     o_count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                          o_perf_fetched,
  output logic [31:0]                          o_perf_stall
`endif
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH+1);
  localparam int unsigned LW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [XLEN-1:0] BLK_BYTES  = XLEN'(4*FETCH_WIDTH);
  localparam logic [CW:0]     CREDIT_LIM = (CW+1)'(QUEUE_DEPTH - FETCH_WIDTH);
  localparam logic [CW:0]     FW_WIDE    = (CW+1)'(FETCH_WIDTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_addr;
  logic [LW-1:0]   r_start_lane;
  logic [LW-1:0]   r_req_lane;
  logic            r_inflight;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_inst_mem [QUEUE_DEPTH];
  logic [XLEN-1:0] r_pc_mem   [QUEUE_DEPTH];

  logic [CW:0]     w_used;
  logic            w_credit_ok;
  logic            w_issue;
  logic [CW-1:0]   w_enq_n;
  logic [CW-1:0]   w_deq_ext;
  logic [CW-1:0]   w_deq_n;
  logic [LW-1:0]   w_redir_lane;
  logic [XLEN-1:0] w_redir_blk;

  // Credit check, issue decision, enqueue/dequeue counts and redirect decode
  always_comb begin
    w_used       = {1'b0, r_count} + (r_inflight ? FW_WIDE : (CW+1)'(0));
    w_credit_ok  = (w_used <= CREDIT_LIM);
    w_issue      = i_rst_n & ~i_redirect_valid & w_credit_ok;
    w_deq_ext    = CW'(i_deq_count);
    w_redir_blk  = i_redirect_pc & ~(BLK_BYTES - XLEN'(1));
    w_redir_lane = LW'((i_redirect_pc >> 2) & XLEN'(FETCH_WIDTH-1));
    if (r_inflight) begin
      w_enq_n = CW'(FETCH_WIDTH) - CW'(r_req_lane);
    end else begin
      w_enq_n = '0;
    end
    if (w_deq_ext > r_count) begin
      w_deq_n = r_count;
    end else begin
      w_deq_n = w_deq_ext;
    end
  end

  assign o_rom_en   = w_issue;
  assign o_rom_addr = r_fetch_pc;
  assign o_count    = r_count;

  // Fetch PC, in-flight tracking and queue pointers; redirect flushes everything
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc   <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_start_lane <= '0;
      r_req_lane   <= '0;
      r_inflight   <= 1'b0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc   <= w_redir_blk;
      r_start_lane <= w_redir_lane;
      r_inflight   <= 1'b0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else begin
      if (w_issue) begin
        r_fetch_pc   <= r_fetch_pc + BLK_BYTES;
        r_req_addr   <= r_fetch_pc;
        r_req_lane   <= r_start_lane;
        r_start_lane <= '0;
      end
      r_inflight <= w_issue;
      r_tail     <= r_tail + PW'(w_enq_n);
      r_head     <= r_head + PW'(w_deq_n);
      r_count    <= r_count + w_enq_n - w_deq_n;
    end
  end

  // Write the returned lanes (from the start lane upward) into queue storage
  always_ff @(posedge i_clk) begin
    if (r_inflight && !i_redirect_valid) begin
      for (int k = 0; k < int'(FETCH_WIDTH); k++) begin
        if (k >= int'(r_req_lane)) begin
          r_inst_mem[r_tail + PW'(k - int'(r_req_lane))] <= i_rom_inst[k*XLEN +: XLEN];
          r_pc_mem[r_tail + PW'(k - int'(r_req_lane))]   <= r_req_addr + XLEN'(4*k);
        end
      end
    end
  end

  // Present the oldest entries to decode, lane 0 first
  always_comb begin
    o_inst  = '0;
    o_pc    = '0;
    o_valid = '0;
    for (int k = 0; k < int'(FETCH_WIDTH); k++) begin
      o_inst[k*XLEN +: XLEN] = r_inst_mem[r_head + PW'(k)];
      o_pc[k*XLEN +: XLEN]   = r_pc_mem[r_head + PW'(k)];
      o_valid[k]             = (r_count > CW'(k));
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic [32:0] w_fetch_sum;

  assign w_fetch_sum    = {1'b0, r_perf_fetched} + 33'(w_enq_n);
  assign o_perf_fetched = r_perf_fetched;
  assign o_perf_stall   = r_perf_stall;

  // Saturating counters of enqueued instructions and credit-stall cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_fetched <= 32'd0;
      r_perf_stall   <= 32'd0;
    end else begin
      if (!i_redirect_valid) begin
        r_perf_fetched <= w_fetch_sum[32] ? 32'hFFFF_FFFF : w_fetch_sum[31:0];
        if (!w_credit_ok && (r_perf_stall != 32'hFFFF_FFFF)) begin
          r_perf_stall <= r_perf_stall + 32'd1;
        end
      end
    end
  end
`else
  // Performance counters are absent in this build.
`endif

  fetch_queue_chk #(
    .CW          (CW),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_chk (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_redirect_valid (i_redirect_valid),
    .i_count          (r_count),
    .i_enq_n          (w_enq_n),
    .i_deq_n          (w_deq_n)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized self-checking bench for fetch_queue using a
// queue-level reference model of fetch, credit, redirect and dequeue.

module tb_fetch_queue;

  localparam int XLEN = 32;
  localparam int FW   = 2;
  localparam int QD   = 8;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic                 i_clk;
  logic                 i_rst_n;
  logic                 i_redirect_valid;
  logic [XLEN-1:0]      i_redirect_pc;
  logic                 o_rom_en;
  logic [XLEN-1:0]      o_rom_addr;
  logic [FW*XLEN-1:0]   i_rom_inst;
  logic [FW*XLEN-1:0]   o_inst;
  logic [FW*XLEN-1:0]   o_pc;
  logic [FW-1:0]        o_valid;
  logic [1:0]           i_deq_count;
  logic [3:0]           o_count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]          o_perf_fetched;
  logic [31:0]          o_perf_stall;
`endif

  fetch_queue #(
    .XLEN(XLEN), .FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .RESET_PC(RPC)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_rom_en         (o_rom_en),
    .o_rom_addr       (o_rom_addr),
    .i_rom_inst       (i_rom_inst),
    .o_inst           (o_inst),
    .o_pc             (o_pc),
    .o_valid          (o_valid),
    .i_deq_count      (i_deq_count),
    .o_count          (o_count)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .o_perf_fetched   (o_perf_fetched),
    .o_perf_stall     (o_perf_stall)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // Synchronous ROM with one cycle of read latency
  logic [XLEN-1:0] rom_q [FW];
  always @(posedge i_clk) begin
    if (o_rom_en) begin
      for (int k = 0; k < FW; k++) rom_q[k] <= rom_word(o_rom_addr + 32'(4*k));
    end
  end
  always_comb begin
    i_rom_inst = '0;
    for (int k = 0; k < FW; k++) i_rom_inst[k*XLEN +: XLEN] = rom_q[k];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: program-order list of buffered PCs plus fetch state
  logic [31:0] q[$];
  logic [31:0] m_pc;
  int          m_lane;
  logic        m_inflight;
  logic [31:0] m_iaddr;
  int          m_ilane;
  logic        have_prev;
  logic [31:0] prev_pc;
  int          n_reqs;

  logic        obs_en;
  logic [31:0] obs_addr;
  logic [3:0]  obs_count;
  logic [1:0]  obs_valid;
  logic [31:0] obs_pc0, obs_pc1, obs_inst0;

  task automatic model_reset();
    q.delete();
    m_pc       = RPC;
    m_lane     = 0;
    m_inflight = 1'b0;
    m_iaddr    = 32'd0;
    m_ilane    = 0;
    have_prev  = 1'b0;
  endtask

  task automatic cycle(input logic redir, input logic [31:0] rpc, input int deq);
    int   sz;
    int   ndeq;
    logic exp_en;
    logic [31:0] lane_pc;
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    i_deq_count      = 2'(deq);
    @(negedge i_clk);
    sz     = q.size();
    exp_en = !redir && ((QD - sz - (m_inflight ? FW : 0)) >= FW);
    check_val("rom_en", 32'(o_rom_en), 32'(exp_en));
    check_val("rom_addr", o_rom_addr, m_pc);
    check_val("count", 32'(o_count), 32'(sz));
    check_val("count_bound", 32'(o_count <= 4'(QD)), 32'd1);
    for (int k = 0; k < FW; k++) begin
      check_val("valid", 32'(o_valid[k]), 32'(sz > k));
      if (sz > k) begin
        check_val("lane_pc", o_pc[k*XLEN +: XLEN], q[k]);
        check_val("lane_inst", o_inst[k*XLEN +: XLEN], rom_word(q[k]));
      end
    end
    obs_en    = o_rom_en;
    obs_addr  = o_rom_addr;
    obs_count = o_count;
    obs_valid = o_valid;
    obs_pc0   = o_pc[0 +: XLEN];
    obs_pc1   = o_pc[XLEN +: XLEN];
    obs_inst0 = o_inst[0 +: XLEN];
    if (o_rom_en) n_reqs++;
    if (redir) begin
      q.delete();
      m_inflight = 1'b0;
      m_pc       = rpc & ~32'(4*FW-1);
      m_lane     = int'((rpc >> 2) % FW);
      have_prev  = 1'b0;
    end else begin
      ndeq = (deq < sz) ? deq : sz;
      for (int i = 0; i < ndeq; i++) begin
        lane_pc = o_pc[i*XLEN +: XLEN];
        if (have_prev) check_val("stream", lane_pc, prev_pc + 32'd4);
        prev_pc   = lane_pc;
        have_prev = 1'b1;
        void'(q.pop_front());
      end
      if (m_inflight) begin
        for (int l = m_ilane; l < FW; l++) q.push_back(m_iaddr + 32'(4*l));
      end
      if (exp_en) begin
        m_iaddr    = m_pc;
        m_ilane    = m_lane;
        m_lane     = 0;
        m_pc       = m_pc + 32'(4*FW);
        m_inflight = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
    return $urandom & 32'h0000_FFFC;
  endfunction

  initial begin
    i_rst_n          = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 32'd0;
    i_deq_count      = 2'd0;
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_val("rst_rom_en", 32'(o_rom_en), 32'd0);
    check_val("rst_rom_addr", o_rom_addr, RPC);
    check_val("rst_count", 32'(o_count), 32'd0);
    check_val("rst_valid", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Fill with no dequeue: four requests then the queue is full
    n_reqs = 0;
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 0);
    check_val("fill_reqs", 32'(n_reqs), 32'd4);
    check_val("fill_count", 32'(obs_count), 32'd8);
    check_val("fill_pc0", obs_pc0, 32'h0);
    check_val("fill_pc1", obs_pc1, 32'h4);

    // Steady state with full-width dequeue: one request every cycle
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 2);
    n_reqs = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 2);
    check_val("steady_reqs", 32'(n_reqs), 32'd10);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 0);

    // Redirect with six entries held and a request in flight
    cycle(1'b0, 32'd0, 2);
    cycle(1'b0, 32'd0, 0);
    cycle(1'b1, 32'h104, 0);
    check_val("pre_redir_count", 32'(obs_count), 32'd6);
    cycle(1'b0, 32'd0, 0);
    check_val("redir_count", 32'(obs_count), 32'd0);
    check_val("redir_addr", obs_addr, 32'h100);
    check_val("redir_en", 32'(obs_en), 32'd1);
    cycle(1'b0, 32'd0, 0);
    cycle(1'b0, 32'd0, 2);
    check_val("tgt_valid", 32'(obs_valid), 32'h1);
    check_val("tgt_pc", obs_pc0, 32'h104);
    check_val("tgt_inst", obs_inst0, rom_word(32'h104));
    cycle(1'b0, 32'd0, 0);
    check_val("clamp_count", 32'(obs_count), 32'd2);
    check_val("clamp_pc", obs_pc0, 32'h108);

    // Pointer wrap with alternating dequeue widths
    for (int i = 0; i < 40; i++) cycle(1'b0, 32'd0, (i % 2 == 0) ? 1 : 2);

    // Random traffic with occasional redirects
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) cycle(1'b1, rand_target(), $urandom_range(0, FW));
      else cycle(1'b0, 32'd0, $urandom_range(0, FW));
    end

    // Asynchronous reset between clock edges
    #2;
    i_rst_n = 1'b0;
    #1;
    check_val("arst_rom_en", 32'(o_rom_en), 32'd0);
    check_val("arst_rom_addr", o_rom_addr, RPC);
    check_val("arst_count", 32'(o_count), 32'd0);
    check_val("arst_valid", 32'(o_valid), 32'd0);
    i_redirect_valid = 1'b0;
    i_deq_count      = 2'd0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 32'd0, 0);
    check_val("post_rst_en", 32'(obs_en), 32'd1);
    check_val("post_rst_addr", obs_addr, RPC);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 15) == 0) cycle(1'b1, rand_target(), $urandom_range(0, FW));
      else cycle(1'b0, 32'd0, $urandom_range(0, FW));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
